// File: rtl/sync_fifo_pkg.sv
// Shared constants, width helpers and the status-flag bundle for the parameterised synchronous FIFO.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    // Pointer width never drops below one bit, even for the smallest legal DEPTH.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // The count needs one more bit than the pointer so that DEPTH itself is representable.
    function automatic int count_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one registered read port.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_width(DEF_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // The array itself is never cleared; a reset only empties the FIFO logically.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The output register is cleared on reset and holds whenever no read is accepted.
    // A read and write to the same address in one cycle returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with registered data, status flags and overflow/underflow reporting.
// Define SYNC_FIFO_PARAM_STICKY_ERR_EN to make OVER/UNDER latch until reset instead of pulsing.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          WR,
    input  logic                          RD,
    input  logic [WIDTH-1:0]              DIN,
    output logic [WIDTH-1:0]              DOUT,
    output logic                          VALID,
    output logic                          FULL,
    output logic                          EMPTY,
    output logic                          ALMOST_FULL,
    output logic                          ALMOST_EMPTY,
    output logic                          OVER,
    output logic                          UNDER,
    output logic [count_width(DEPTH)-1:0] COUNT
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_param: WIDTH must be at least 1");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
        end
        if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
            $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
        end
        if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
            $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    fifo_flags_t   r_flags;
    logic          r_valid;
    logic          r_over;
    logic          r_under;

    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_over_ev;
    logic          w_under_ev;
    logic [CW-1:0] w_count_nxt;
    fifo_flags_t   w_flags_nxt;

    // Request/accept rule: a read is taken whenever the FIFO holds data; a write is taken
    // when there is room or when a read in the same cycle frees a slot. Anything else is
    // rejected and reported one cycle later on OVER/UNDER.
    assign w_rd_acc   = RD && !r_flags.empty;
    assign w_wr_acc   = WR && (!r_flags.full || w_rd_acc);
    assign w_over_ev  = WR && !w_wr_acc;
    assign w_under_ev = RD && r_flags.empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are computed from the count that will be in place after this edge.
    always_comb begin
        w_flags_nxt              = '0;
        w_flags_nxt.full         = (w_count_nxt == FULL_CNT);
        w_flags_nxt.empty        = (w_count_nxt == '0);
        w_flags_nxt.almost_full  = (w_count_nxt >= AF_CNT);
        w_flags_nxt.almost_empty = (w_count_nxt <= AE_CNT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_flags  <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
        end else begin
            // DEPTH is a power of two, so pointer overflow is exactly the modulo wrap.
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= w_rd_acc;
            r_flags <= w_flags_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_over  <= 1'b0;
            r_under <= 1'b0;
        end else begin
`ifdef SYNC_FIFO_PARAM_STICKY_ERR_EN
            r_over  <= r_over  | w_over_ev;
            r_under <= r_under | w_under_ev;
`else
            r_over  <= w_over_ev;
            r_under <= w_under_ev;
`endif
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (DIN),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (DOUT)
    );

    assign VALID        = r_valid;
    assign FULL         = r_flags.full;
    assign EMPTY        = r_flags.empty;
    assign ALMOST_FULL  = r_flags.almost_full;
    assign ALMOST_EMPTY = r_flags.almost_empty;
    assign OVER         = r_over;
    assign UNDER        = r_under;
    assign COUNT        = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param at WIDTH=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1: vector table plus scoreboard.
module tb_sync_fifo_param;

    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

`ifdef SYNC_FIFO_PARAM_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic         CLK;
    logic         RST;
    logic         WR;
    logic         RD;
    logic [W-1:0] DIN;
    logic [W-1:0] DOUT;
    logic         VALID;
    logic         FULL;
    logic         EMPTY;
    logic         ALMOST_FULL;
    logic         ALMOST_EMPTY;
    logic         OVER;
    logic         UNDER;
    logic [3:0]   COUNT;

    sync_fifo_param #(
        .WIDTH    (W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .WR           (WR),
        .RD           (RD),
        .DIN          (DIN),
        .DOUT         (DOUT),
        .VALID        (VALID),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .OVER         (OVER),
        .UNDER        (UNDER),
        .COUNT        (COUNT)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- counters and reference model ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] mq[$];     // model contents
    logic [W-1:0] exp_q[$];  // expected read data, in order
    logic [W-1:0] m_dout;
    bit           m_valid;
    bit           m_over;
    bit           m_under;

    typedef struct {
        bit           rst;
        bit           wr;
        bit           rd;
        logic [W-1:0] din;
        int           cnt;
        bit           full;
        bit           empty;
        bit           af;
        bit           ae;
        bit           over;
        bit           under;
        bit           valid;
        logic [W-1:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of requests, advances the model and pops the scoreboard on VALID.
    task automatic step(input bit rst, input bit wr, input bit rd, input logic [W-1:0] din);
        bit ra;
        bit wa;
        RST = rst;
        WR  = wr;
        RD  = rd;
        DIN = din;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_over  = 1'b0;
            m_under = 1'b0;
        end else begin
            ra = rd && (mq.size() != 0);
            wa = wr && ((mq.size() != DEPTH) || ra);
            m_valid = ra;
            if (ra) begin
                m_dout = mq.pop_front();
                exp_q.push_back(m_dout);
            end
            if (wa) mq.push_back(din);
            m_over  = (STICKY && m_over)  || (wr && !wa);
            m_under = (STICKY && m_under) || (rd && !ra);
        end
        @(posedge CLK);
        #1;
        if (VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_spurious_valid: got DOUT 0x%0h with nothing expected", DOUT);
            end else begin
                chk("sb_dout", 32'(DOUT), 32'(exp_q.pop_front()));
            end
        end else if (m_valid && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check_model(input string tag);
        int c;
        c = mq.size();
        chk({tag, "_count"}, 32'(COUNT),        32'(c));
        chk({tag, "_full"},  32'(FULL),         32'(c == DEPTH));
        chk({tag, "_empty"}, 32'(EMPTY),        32'(c == 0));
        chk({tag, "_af"},    32'(ALMOST_FULL),  32'(c >= AF));
        chk({tag, "_ae"},    32'(ALMOST_EMPTY), 32'(c <= AE));
        chk({tag, "_over"},  32'(OVER),         32'(m_over));
        chk({tag, "_under"}, 32'(UNDER),        32'(m_under));
        chk({tag, "_valid"}, 32'(VALID),        32'(m_valid));
        chk({tag, "_dout"},  32'(DOUT),         32'(m_dout));
    endtask

    function automatic vec_t mk(bit rst, bit wr, bit rd, logic [W-1:0] din, int cnt,
                                bit full, bit empty, bit af, bit ae, bit over, bit under,
                                bit valid, logic [W-1:0] dout);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
        v.full = full; v.empty = empty; v.af = af; v.ae = ae;
        v.over = over; v.under = under; v.valid = valid; v.dout = dout;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int k;
        RST = 1'b1; WR = 1'b0; RD = 1'b0; DIN = '0;

        // Fill / overflow / drain / underflow table.
        vecs.push_back(mk(1, 0, 0, 16'h0, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 16'(i), i, i == 8, 0, i >= 6, i <= 1, 0, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 16'h0009, 8, 1, 0, 1, 0, 1, 0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 0, 16'h0, 8, 1, 0, 1, 0, STICKY, 0, 0, 16'h0));
        for (int i = 1; i <= 8; i++) begin
            k = 8 - i;
            vecs.push_back(mk(0, 0, 1, 16'h0, k, 0, k == 0, k >= 6, k <= 1, STICKY, 0, 1, 16'(i)));
        end
        vecs.push_back(mk(0, 0, 1, 16'h0, 0, 0, 1, 0, 1, STICKY, 1, 0, 16'h0008));
        vecs.push_back(mk(0, 0, 0, 16'h0, 0, 0, 1, 0, 1, STICKY, STICKY, 0, 16'h0008));

        step(1, 0, 0, '0);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk($sformatf("v%0d_count", i), 32'(COUNT),        32'(vecs[i].cnt));
            chk($sformatf("v%0d_full", i),  32'(FULL),         32'(vecs[i].full));
            chk($sformatf("v%0d_empty", i), 32'(EMPTY),        32'(vecs[i].empty));
            chk($sformatf("v%0d_af", i),    32'(ALMOST_FULL),  32'(vecs[i].af));
            chk($sformatf("v%0d_ae", i),    32'(ALMOST_EMPTY), 32'(vecs[i].ae));
            chk($sformatf("v%0d_over", i),  32'(OVER),         32'(vecs[i].over));
            chk($sformatf("v%0d_under", i), 32'(UNDER),        32'(vecs[i].under));
            chk($sformatf("v%0d_valid", i), 32'(VALID),        32'(vecs[i].valid));
            chk($sformatf("v%0d_dout", i),  32'(DOUT),         32'(vecs[i].dout));
        end

        // Full with simultaneous write and read: both accepted, 0xAAAA comes out last.
        step(1, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 16'($urandom_range(0, 16'hFFFF)));
        step(0, 1, 1, 16'hAAAA);
        chk("fullrw_count", 32'(COUNT), 32'd8);
        chk("fullrw_full",  32'(FULL),  32'd1);
        chk("fullrw_over",  32'(OVER),  32'd0);
        check_model("fullrw");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);
        chk("fullrw_last", 32'(DOUT), 32'h0000AAAA);
        check_model("fullrw_drain");

        // Empty with simultaneous write and read: only the write is taken.
        step(1, 0, 0, '0);
        step(0, 1, 1, 16'h1234);
        chk("emptyrw_count", 32'(COUNT), 32'd1);
        chk("emptyrw_under", 32'(UNDER), 32'd1);
        chk("emptyrw_valid", 32'(VALID), 32'd0);
        check_model("emptyrw");

        // Pointer wrap: interleaved write/read pairs on top of a small preload.
        step(1, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 16'($urandom_range(0, 16'hFFFF)));
            check_model("wrap_w");
            step(0, 0, 1, '0);
            check_model("wrap_r");
        end

        // Random traffic with the full model compare every cycle.
        for (int i = 0; i < 150; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)));
            check_model("rand");
        end

        // Overflow, then partial drain to 5, then reset overriding a write and read.
        step(1, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 16'(i + 16'h100));
        step(0, 1, 0, 16'hDEAD);
        chk("rst_over_pulse", 32'(OVER), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
        step(0, 0, 0, '0);
        chk("rst_pre_count", 32'(COUNT), 32'd5);
        chk("rst_over_persist", 32'(OVER), 32'(STICKY));
        step(1, 1, 1, 16'hBEEF);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_dout",  32'(DOUT),  32'd0);
        chk("rst_over",  32'(OVER),  32'd0);
        check_model("rst");
        step(0, 0, 1, '0);
        chk("rst_discard_under", 32'(UNDER), 32'd1);
        chk("rst_discard_valid", 32'(VALID), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, ALMOST_FULL threshold (1..DEPTH).
REQ-004 The block SHALL have parameter AE_LEVEL, default 1, ALMOST_EMPTY threshold (0..DEPTH-1).
REQ-005 The block SHALL have port CLK, input, 1 bit, clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit, reset; synchronous, active-high.
REQ-007 The block SHALL have port WR, input, 1 bit, write request.
REQ-008 The block SHALL have port RD, input, 1 bit, read request.
REQ-009 The block SHALL have port DIN, input, WIDTH bits, write data.
REQ-010 The block SHALL have port DOUT, output, WIDTH bits, registered read data.
REQ-011 The block SHALL have port VALID, output, 1 bit, DOUT carries a newly read word.
REQ-012 The block SHALL have ports FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, outputs, 1 bit each, registered status flags.
REQ-013 The block SHALL have ports OVER and UNDER, outputs, 1 bit each, rejected-write and rejected-read indicators.
REQ-014 The block SHALL have port COUNT, output, clog2(DEPTH)+1 bits, registered occupancy 0..DEPTH.

Function
REQ-015 rd_acc SHALL equal RD && !EMPTY; wr_acc SHALL equal WR && (!FULL || rd_acc). Full plus simultaneous read and write SHALL accept both.
REQ-016 On wr_acc, DIN SHALL be stored at wr_ptr and wr_ptr SHALL advance modulo DEPTH; DEPTH-1 wraps to 0.
REQ-017 On rd_acc, DOUT SHALL load mem[rd_ptr] at that edge, rd_ptr SHALL advance modulo DEPTH, and VALID SHALL be 1 for exactly the following cycle; latency RD to data is 1 cycle.
REQ-018 Without rd_acc, DOUT SHALL hold its value and VALID SHALL be 0.
REQ-019 WR while EMPTY with RD in the same cycle SHALL accept only the write; the read SHALL be rejected.
REQ-020 COUNT SHALL update to COUNT + wr_acc - rd_acc each edge, never leaving 0..DEPTH.
REQ-021 Flags SHALL be registered from the next count: FULL = (next==DEPTH), EMPTY = (next==0), ALMOST_FULL = (next>=AF_LEVEL), ALMOST_EMPTY = (next<=AE_LEVEL); each is therefore valid in the cycle after the accepting edge.
REQ-022 OVER SHALL be 1 in the cycle after WR && !wr_acc; UNDER SHALL be 1 in the cycle after RD && EMPTY.
REQ-023 Rejected requests SHALL leave pointers, COUNT, memory and DOUT unchanged.

Reset
REQ-024 On RST, pointers, COUNT, DOUT, VALID, FULL, ALMOST_FULL, OVER and UNDER SHALL clear to 0, and EMPTY and ALMOST_EMPTY SHALL set to 1 (ALMOST_EMPTY also when AE_LEVEL=0).
REQ-025 RST SHALL override WR/RD in the same cycle, and reset mid-operation SHALL discard all contents; memory is not cleared.

Configuration
REQ-026 With SYNC_FIFO_PARAM_STICKY_ERR_EN defined, OVER and UNDER SHALL latch at 1 once set and clear only on RST.
REQ-027 Without SYNC_FIFO_PARAM_STICKY_ERR_EN, OVER and UNDER SHALL be single-cycle pulses per REQ-022.

Structure
REQ-028 Package sync_fifo_pkg SHALL hold the default WIDTH/DEPTH constants and the pointer/count width helper function.
REQ-029 Storage SHALL be a sub-module sync_fifo_ram: a simple dual-port array with one write port and one registered read port.
REQ-030 Parameter legality (power-of-two DEPTH, threshold ranges) SHALL be checked at elaboration.

Verification (WIDTH=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1)
REQ-031 Fill test: write 8 words 0x0001..0x0008 -> ALMOST_EMPTY=0 after the 2nd write, ALMOST_FULL=1 after the 6th, FULL=1 and COUNT=8 after the 8th; a 9th WR gives OVER=1 for 1 cycle and the data is dropped.
REQ-032 Drain test: then 8 RDs -> DOUT=0x0001..0x0008 in order, VALID each cycle after RD, EMPTY=1 after the 8th; a 9th RD gives UNDER=1 and DOUT stays 0x0008.
REQ-033 Full plus simultaneous WR/RD with DIN=0xAAAA -> COUNT stays 8, FULL stays 1, OVER=0, and 0xAAAA is read out last.
REQ-034 Empty plus simultaneous WR/RD -> write only, COUNT=1, UNDER=1, VALID=0.
REQ-035 Wrap test: 20 interleaved write/read pairs -> data order preserved across pointer wrap, COUNT bounded.
REQ-036 Reset test: RST asserted with COUNT=5 -> next cycle COUNT=0, EMPTY=1, DOUT=0; run with and without SYNC_FIFO_PARAM_STICKY_ERR_EN to confirm OVER persistence.
